// File: rtl/serial_eq_pkg.sv
// Shared definitions for the bit-serial word comparator: state encoding and default word size.
package serial_eq_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/xnor_nor.sv
// Two-input XNOR built only from five 2-input NOR gates.
module xnor_nor (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n_a;
  logic n_b;
  logic a_lo_b_hi;
  logic a_hi_b_lo;

  // Inverters are NORs with both inputs tied together.
  assign n_a       = ~(a | a);
  assign n_b       = ~(b | b);
  // ~a & b
  assign a_lo_b_hi = ~(a | n_b);
  // a & ~b
  assign a_hi_b_lo = ~(n_a | b);
  // Neither "differs" term set -> inputs equal.
  assign y         = ~(a_lo_b_hi | a_hi_b_lo);

endmodule

// File: rtl/serial_equality_checker.sv
// Bit-serial equality checker: compares two LSB-first streams over a WIDTH-bit word, reporting
// equal, mismatch count and index of the first mismatching bit, framed by start/busy/done.
module serial_equality_checker
  import serial_eq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a,
  input  logic          b,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [CW-1:0] mismatches,
  output logic [CW-1:0] first_miss
);

  localparam logic [CW-1:0] WidthC  = CW'(WIDTH);
  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Running accumulators for the word in flight.
  logic [CW-1:0] acc_miss_q, acc_miss_d;
  logic [CW-1:0] acc_first_q, acc_first_d;
  logic          acc_eq_q, acc_eq_d;

  // Published results, only written on DONE entry or cleared by an accepted start.
  logic [CW-1:0] res_miss_q, res_miss_d;
  logic [CW-1:0] res_first_q, res_first_d;
  logic          res_eq_q, res_eq_d;

  logic          bits_match;

  xnor_nor u_cmp (
    .a (a),
    .b (b),
    .y (bits_match)
  );

  // Next-state, accumulate and result-capture logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_miss_d  = acc_miss_q;
    acc_first_d = acc_first_q;
    acc_eq_d    = acc_eq_q;
    res_miss_d  = res_miss_q;
    res_first_d = res_first_q;
    res_eq_d    = res_eq_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StShift;
          cnt_d       = '0;
          acc_miss_d  = '0;
          acc_first_d = WidthC;
          acc_eq_d    = 1'b1;
          res_miss_d  = '0;
          res_first_d = WidthC;
          res_eq_d    = 1'b0;
        end
      end

      StShift: begin
        if (bit_valid) begin
          if (!bits_match) begin
            acc_miss_d = acc_miss_q + CW'(1);
            acc_eq_d   = 1'b0;
            // WidthC doubles as the "no mismatch seen yet" marker.
            if (acc_first_q == WidthC) begin
              acc_first_d = cnt_q;
            end
          end

          if (cnt_q == LastIdx) begin
            // Last bit: publish the totals including this bit.
            state_d     = StDone;
            cnt_d       = '0;
            res_miss_d  = acc_miss_d;
            res_first_d = acc_first_d;
            res_eq_d    = acc_eq_d;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_miss_q  <= '0;
      acc_first_q <= '0;
      acc_eq_q    <= 1'b0;
      res_miss_q  <= '0;
      res_first_q <= '0;
      res_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_miss_q  <= acc_miss_d;
      acc_first_q <= acc_first_d;
      acc_eq_q    <= acc_eq_d;
      res_miss_q  <= res_miss_d;
      res_first_q <= res_first_d;
      res_eq_q    <= res_eq_d;
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign equal      = res_eq_q;
  assign mismatches = res_miss_q;
  assign first_miss = res_first_q;

  // Counter stays within the word and done is a single-cycle pulse.
  cnt_in_range_a : assert property (@(posedge clk) disable iff (rst) cnt_q <= LastIdx);
  done_pulse_a   : assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_serial_equality_checker.sv
// Directed bench for serial_equality_checker with a queue-based scoreboard and done monitor.
module tb_serial_equality_checker;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    logic          eq;
    logic [CW-1:0] mm;
    logic [CW-1:0] fm;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          busy;
  logic          done;
  logic          equal;
  logic [CW-1:0] mismatches;
  logic [CW-1:0] first_miss;

  logic          ca = 1'b0;
  logic          cb = 1'b0;
  logic          cy;

  exp_t          sb_q[$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  serial_equality_checker #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_valid  (bit_valid),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .equal      (equal),
    .mismatches (mismatches),
    .first_miss (first_miss)
  );

  xnor_nor u_cell (
    .a (ca),
    .b (cb),
    .y (cy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops one expectation per done pulse; a done with nothing queued is an error.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("equal", int'(equal), int'(e.eq));
          check("mismatches", int'(mismatches), int'(e.mm));
          check("first_miss", int'(first_miss), int'(e.fm));
        end
      end
    end
  endtask

  task automatic begin_word(input logic eq, input int mm, input int fm, input int stalls);
    exp_t e;
    start = 1'b1;
    tick();
    start = 1'b0;
    e.eq  = eq;
    e.mm  = CW'(mm);
    e.fm  = CW'(fm);
    e.cyc = cyc + W + stalls;
    sb_q.push_back(e);
  endtask

  task automatic send_bits(input logic [W-1:0] aw, input logic [W-1:0] bw, input int nbits,
                           input int stall_after, input int nstall, input bit pulse_start);
    for (int i = 0; i < nbits; i++) begin
      bit_valid = 1'b1;
      a = aw[i];
      b = bw[i];
      tick();
      if (i == stall_after) begin
        bit_valid = 1'b0;
        for (int k = 0; k < nstall; k++) begin
          if (pulse_start && k == 1) start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
    end
    bit_valid = 1'b0;
    a = 1'b0;
    b = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic eq, input int mm, input int fm);
    check({tag, "_equal"}, int'(equal), int'(eq));
    check({tag, "_mismatches"}, int'(mismatches), mm);
    check({tag, "_first_miss"}, int'(first_miss), fm);
  endtask

  initial begin
    // Exhaustive check of the NOR-built XNOR cell.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      ca = ab[1];
      cb = ab[0];
      #1;
      check("xnor_cell", int'(cy), (ab[1] == ab[0]) ? 1 : 0);
    end

    fork
      monitor();
    join_none

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_results("rst", 1'b0, 0, 0);

    // Equal words.
    begin_word(1'b1, 0, 8, 0);
    check("busy_after_start", int'(busy), 1);
    send_bits(8'hA5, 8'hA5, W, -1, 0, 1'b0);
    check("busy_in_done", int'(busy), 0);
    tick();
    repeat (3) tick();
    check_results("hold_w1", 1'b1, 0, 8);

    // Low nibble differs.
    begin_word(1'b0, 4, 0, 0);
    send_bits(8'hFF, 8'hF0, W, -1, 0, 1'b0);
    tick();

    // Only the MSB differs.
    begin_word(1'b0, 1, 7, 0);
    send_bits(8'h00, 8'h80, W, -1, 0, 1'b0);
    tick();

    // Three stall cycles after bit 2, with a start pulse that must be ignored.
    begin_word(1'b0, 4, 0, 3);
    send_bits(8'hFF, 8'hF0, W, 2, 3, 1'b1);
    tick();
    check_results("stall_hold", 1'b0, 4, 0);

    // Reset mid-word: no expectation queued, so any done pulse is flagged.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'hFF, 8'h00, 5, -1, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check_results("midrst", 1'b0, 0, 0);
    repeat (4) tick();

    // Recovery word: only bit 2 differs.
    begin_word(1'b0, 1, 2, 0);
    send_bits(8'h12, 8'h16, W, -1, 0, 1'b0);

    // Start raised in the done cycle (ignored) and held into the first idle cycle (accepted).
    start = 1'b1;
    tick();
    begin_word(1'b0, 8, 0, 0);
    send_bits(8'h5A, 8'hA5, W, -1, 0, 1'b0);
    tick();
    repeat (5) tick();
    check_results("hold_w6", 1'b0, 8, 0);

    check("pending_done", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
